// File: rtl/dmux16_dispatcher.sv
// Valid/ready front-end that steers 16-bit words to one of two channels,
// each with a one-entry holding register; ROUND mode alternates every BURST words.
module dmux16_dispatcher #(
  parameter int BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode,
  input  logic [15:0] in_data,
  input  logic        in_dest,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] a_data,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [15:0] b_data,
  output logic        b_valid,
  input  logic        b_ready,
  output logic        cur_sel,
  output logic [3:0]  burst_cnt
);

  localparam logic [3:0] LP_LAST = 4'(BURST - 1);

  logic [15:0] r_a_data, r_b_data;
  logic        r_a_valid, r_b_valid;
  logic        r_cur_sel;
  logic [3:0]  r_burst_cnt;

  logic        w_tgt;
  logic        w_tgt_valid;
  logic        w_tgt_ready;
  logic        w_accept;
  logic [15:0] w_leg_a, w_leg_b;
  logic        w_load_a, w_load_b;
  logic        w_drain_a, w_drain_b;

  assign w_tgt       = mode ? r_cur_sel : in_dest;
  assign w_tgt_valid = w_tgt ? r_b_valid : r_a_valid;
  assign w_tgt_ready = w_tgt ? b_ready : a_ready;
  assign in_ready    = !w_tgt_valid || w_tgt_ready;
  assign w_accept    = in_valid && in_ready;

  // DMux16 stage: the unselected leg carries zero
  assign w_leg_a = w_tgt ? 16'h0000 : in_data;
  assign w_leg_b = w_tgt ? in_data : 16'h0000;

  assign w_load_a  = w_accept && !w_tgt;
  assign w_load_b  = w_accept && w_tgt;
  assign w_drain_a = r_a_valid && a_ready;
  assign w_drain_b = r_b_valid && b_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_data  <= 16'h0000;
      r_a_valid <= 1'b0;
    end else if (w_load_a) begin
      r_a_data  <= w_leg_a;
      r_a_valid <= 1'b1;
    end else if (w_drain_a) begin
      r_a_data  <= 16'h0000;
      r_a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_b_data  <= 16'h0000;
      r_b_valid <= 1'b0;
    end else if (w_load_b) begin
      r_b_data  <= w_leg_b;
      r_b_valid <= 1'b1;
    end else if (w_drain_b) begin
      r_b_data  <= 16'h0000;
      r_b_valid <= 1'b0;
    end
  end

  // DIRECT mode zeroes the burst count but keeps the ROUND destination
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_sel   <= 1'b0;
      r_burst_cnt <= 4'd0;
    end else if (!mode) begin
      r_burst_cnt <= 4'd0;
    end else if (w_accept) begin
      if (r_burst_cnt == LP_LAST) begin
        r_cur_sel   <= ~r_cur_sel;
        r_burst_cnt <= 4'd0;
      end else begin
        r_burst_cnt <= r_burst_cnt + 4'd1;
      end
    end
  end

  assign a_data    = r_a_data;
  assign a_valid   = r_a_valid;
  assign b_data    = r_b_data;
  assign b_valid   = r_b_valid;
  assign cur_sel   = r_cur_sel;
  assign burst_cnt = r_burst_cnt;

endmodule

// File: tb/tb_dmux16_dispatcher.sv
// Self-checking bench: vector table for per-cycle outputs plus a per-channel
// scoreboard that tracks every accepted word to its drain.
module tb_dmux16_dispatcher;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [15:0] in_data;
  logic        in_dest;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic        cur_sel;
  logic [3:0]  burst_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  dmux16_dispatcher #(.BURST(BURST)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .cur_sel(cur_sel), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected words per channel, plus an independent scheduler model
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic        m_sel = 1'b0;
  logic [3:0]  m_cnt = 4'd0;

  always @(posedge clk) begin
    logic tgt;
    logic [15:0] w;
    if (reset) begin
      q_a.delete();
      q_b.delete();
      m_sel = 1'b0;
      m_cnt = 4'd0;
    end else begin
      chk("sb_cur_sel", 32'(cur_sel), 32'(m_sel));
      chk("sb_burst_cnt", 32'(burst_cnt), 32'(m_cnt));
      if (!a_valid) chk("sb_a_zero", 32'(a_data), 32'h0);
      if (!b_valid) chk("sb_b_zero", 32'(b_data), 32'h0);
      if (a_valid && a_ready) begin
        if (q_a.size() == 0) chk("sb_a_unexpected", 32'(a_data), 32'hFFFF_FFFF);
        else begin w = q_a.pop_front(); chk("sb_a_data", 32'(a_data), 32'(w)); end
      end
      if (b_valid && b_ready) begin
        if (q_b.size() == 0) chk("sb_b_unexpected", 32'(b_data), 32'hFFFF_FFFF);
        else begin w = q_b.pop_front(); chk("sb_b_data", 32'(b_data), 32'(w)); end
      end
      tgt = mode ? m_sel : in_dest;
      if (in_valid && in_ready) begin
        if (tgt) q_b.push_back(in_data);
        else     q_a.push_back(in_data);
      end
      if (!mode) m_cnt = 4'd0;
      else if (in_valid && in_ready) begin
        if (m_cnt == 4'(BURST - 1)) begin
          m_sel = ~m_sel;
          m_cnt = 4'd0;
        end else m_cnt = m_cnt + 4'd1;
      end
    end
  end

  typedef struct {
    logic        mode;
    logic        dest;
    logic        vld;
    logic [15:0] data;
    logic        ar;
    logic        br;
    logic        e_rdy;
    logic        e_av;
    logic [15:0] e_ad;
    logic        e_bv;
    logic [15:0] e_bd;
    logic        e_sel;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic md, logic d, logic v, logic [15:0] dt, logic ar, logic br,
                              logic rdy, logic av, logic [15:0] ad, logic bv, logic [15:0] bd,
                              logic sel, logic [3:0] cnt);
    vec_t r;
    r.mode = md; r.dest = d; r.vld = v; r.data = dt; r.ar = ar; r.br = br;
    r.e_rdy = rdy; r.e_av = av; r.e_ad = ad; r.e_bv = bv; r.e_bd = bd;
    r.e_sel = sel; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic check_outputs(input string tag, input logic av, input logic [15:0] ad,
                               input logic bv, input logic [15:0] bd,
                               input logic sel, input logic [3:0] cnt);
    chk({tag, "_a_valid"}, 32'(a_valid), 32'(av));
    chk({tag, "_a_data"}, 32'(a_data), 32'(ad));
    chk({tag, "_b_valid"}, 32'(b_valid), 32'(bv));
    chk({tag, "_b_data"}, 32'(b_data), 32'(bd));
    chk({tag, "_cur_sel"}, 32'(cur_sel), 32'(sel));
    chk({tag, "_burst_cnt"}, 32'(burst_cnt), 32'(cnt));
  endtask

  task automatic drive(input logic md, input logic d, input logic v, input logic [15:0] dt,
                       input logic ar, input logic br);
    mode = md; in_dest = d; in_valid = v; in_data = dt; a_ready = ar; b_ready = br;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // DIRECT steering
    vecs.push_back(mk(0,1,1,16'hBEEF,1,1, 1, 0,16'h0000, 1,16'hBEEF, 0,0));
    vecs.push_back(mk(0,0,1,16'h1234,1,1, 1, 1,16'h1234, 0,16'h0000, 0,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,1, 1, 0,16'h0000, 0,16'h0000, 0,0));
    // backpressure and bubble-free replace on A
    vecs.push_back(mk(0,0,1,16'h1111,0,1, 1, 1,16'h1111, 0,16'h0000, 0,0));
    vecs.push_back(mk(0,0,1,16'h2222,0,1, 0, 1,16'h1111, 0,16'h0000, 0,0));
    vecs.push_back(mk(0,0,1,16'h2222,1,1, 1, 1,16'h2222, 0,16'h0000, 0,0));
    // no head-of-line blocking: A full and stalled, B still accepts
    vecs.push_back(mk(0,1,1,16'h5A5A,0,1, 1, 1,16'h2222, 1,16'h5A5A, 0,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,1, 1, 0,16'h0000, 0,16'h0000, 0,0));
    // ROUND bursts of 4
    vecs.push_back(mk(1,0,1,16'h0001,1,1, 1, 1,16'h0001, 0,16'h0000, 0,1));
    vecs.push_back(mk(1,0,1,16'h0002,1,1, 1, 1,16'h0002, 0,16'h0000, 0,2));
    vecs.push_back(mk(1,1,1,16'h0003,1,1, 1, 1,16'h0003, 0,16'h0000, 0,3));
    vecs.push_back(mk(1,1,1,16'h0004,1,1, 1, 1,16'h0004, 0,16'h0000, 1,0));
    vecs.push_back(mk(1,0,1,16'h0005,1,1, 1, 0,16'h0000, 1,16'h0005, 1,1));
    vecs.push_back(mk(1,0,1,16'h0006,1,1, 1, 0,16'h0000, 1,16'h0006, 1,2));
    vecs.push_back(mk(1,0,1,16'h0007,1,1, 1, 0,16'h0000, 1,16'h0007, 1,3));
    vecs.push_back(mk(1,0,1,16'h0008,1,1, 1, 0,16'h0000, 1,16'h0008, 0,0));
    vecs.push_back(mk(1,0,0,16'h0000,1,1, 1, 0,16'h0000, 0,16'h0000, 0,0));
    // DIRECT interval clears a partial burst
    vecs.push_back(mk(1,1,1,16'h0009,1,1, 1, 1,16'h0009, 0,16'h0000, 0,1));
    vecs.push_back(mk(0,0,0,16'h0000,1,1, 1, 0,16'h0000, 0,16'h0000, 0,0));

    // Reset held 2 cycles with random inputs
    reset = 1'b1;
    drive(0, 0, 0, 16'h0, 1, 1);
    repeat (2) begin
      @(negedge clk);
      drive(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 16'h0, 1, 1);
    #1;
    check_outputs("reset", 0, 16'h0, 0, 16'h0, 0, 4'd0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].mode, vecs[i].dest, vecs[i].vld, vecs[i].data, vecs[i].ar, vecs[i].br);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].e_av, vecs[i].e_ad, vecs[i].e_bv,
                    vecs[i].e_bd, vecs[i].e_sel, vecs[i].e_cnt);
    end

    // Reset mid-operation: reach a_valid=1 stalled, cur_sel=1, burst_cnt=2
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1, 0, 1, 16'h0100 + 16'(k), 1, 1);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1, 0, 1, 16'h0200 + 16'(k), 0, 1);
    end
    @(negedge clk);
    drive(1, 0, 0, 16'h0, 0, 0);
    check_outputs("pre_rst", 1, 16'h0103, 1, 16'h0201, 1, 4'd2);
    reset = 1'b1;
    drive(1, 1, 1, 16'hDEAD, 1, 1);
    @(posedge clk);
    #1;
    check_outputs("mid_rst", 0, 16'h0, 0, 16'h0, 0, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 16'h0, 1, 1);
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    check_outputs("post_rst", 0, 16'h0, 0, 16'h0, 0, 4'd0);

    @(negedge clk);
    chk("sb_a_left", 32'(q_a.size()), 32'h0);
    chk("sb_b_left", 32'(q_b.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmux16_dispatcher.md
# dmux16_dispatcher

Clocked front-end that sequences the 16-bit demultiplexer datapath. It accepts 16-bit words over a valid/ready input handshake and steers each word to output channel A or B. The destination comes either from a per-word select (DIRECT mode) or from an internal burst-alternating scheduler (ROUND mode). Each channel has a one-entry holding register with its own valid/ready handshake, so a stalled channel never corrupts data and never blocks traffic bound for the other channel.

## Interface
- BURST, 4: words sent to one channel in ROUND mode before switching; legal range 1..15
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- mode  input  1  0 = DIRECT (destination from in_dest), 1 = ROUND (destination from cur_sel)
- in_data  input  16  input word
- in_dest  input  1  DIRECT-mode destination: 0 = A, 1 = B
- in_valid  input  1  in_data/in_dest valid
- in_ready  output  1  dispatcher accepts the word this cycle
- a_data  output  16  channel A word; 0 when a_valid=0
- a_valid  output  1  channel A holds a word
- a_ready  input  1  channel A consumer takes the word
- b_data  output  16  channel B word; 0 when b_valid=0
- b_valid  output  1  channel B holds a word
- b_ready  input  1  channel B consumer takes the word
- cur_sel  output  1  ROUND-mode current destination: 0 = A, 1 = B
- burst_cnt  output  4  words accepted toward cur_sel in the current burst

## Operation
- Target: tgt = in_dest if mode=0, else tgt = cur_sel.
- in_ready = !tgt_valid || tgt_ready. It is combinational from mode, in_dest, cur_sel and the target channel's valid/ready, and is independent of in_valid.
- Accept: in_valid && in_ready. On accept, in_data passes through the DMux16 stage (sel = tgt). The selected leg loads the target holding register, and the other leg carries 0.
- Per-channel register (A shown; B identical):
  - load only: a_data <= word, a_valid <= 1
  - drain only (a_valid && a_ready, no load): a_valid <= 0, a_data <= 0
  - load and drain on the same edge: a_data <= new word, a_valid stays 1, with no bubble
  - neither: hold
- A non-targeted channel drains independently in the same cycle.
- ROUND scheduler, updated only when mode=1:
  - On accept, if burst_cnt == BURST-1: cur_sel <= ~cur_sel and burst_cnt <= 0. Otherwise burst_cnt <= burst_cnt+1.
  - Without accept, cur_sel and burst_cnt hold.
- When mode=0, burst_cnt <= 0 every edge and cur_sel holds its value.
- A ROUND burst therefore restarts from 0 after any DIRECT interval, toward the retained cur_sel.
- No word is ever dropped or duplicated. A word accepted on a clock edge appears on exactly one channel.

## Timing
- Reset, sampled on the rising edge with reset=1, clears all state:
  - a_valid=0, b_valid=0
  - a_data=0, b_data=0
  - cur_sel=0, burst_cnt=0
- After that edge, in_ready=1.
- Reset overrides any simultaneous accept or drain. Words held at reset are discarded.
- Latency: a word accepted at edge N is visible on its channel's data/valid outputs after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle sustained when the target channel's ready=1 every cycle.
- Backpressure: when the target channel is valid and not ready, in_ready=0. The word stays at the input and the producer holds in_data/in_dest stable.
- Mode, in_dest and cur_sel all feed in_ready combinationally. A mode change alters the target in the same cycle, and its counter effect lands at the next edge.
- BURST=1: cur_sel toggles on every accepted word.

## Test plan
- Reset: hold reset 2 cycles with random inputs, then release.
  - Required: a/b_valid=0, a/b_data=0x0000, cur_sel=0, burst_cnt=0, in_ready=1.
- DIRECT steering: mode=0, a_ready=b_ready=1; send 0xBEEF with in_dest=1, then 0x1234 with in_dest=0.
  - After word 1: b_valid=1, b_data=0xBEEF, a_data=0.
  - Next cycle: a_data=0x1234, b_valid=0.
- Backpressure and bubble-free replace: mode=0, a_ready=0; send 0x1111 then 0x2222, both to A.
  - 0x1111 is accepted; in_ready=0 while 0x2222 is presented.
  - Raise a_ready for one cycle: 0x1111 drains, 0x2222 loads on the same edge, a_valid stays 1.
- No head-of-line blocking: mode=0, A full with a_ready=0; send 0x5A5A with in_dest=1.
  - Required: in_ready=1, 0x5A5A appears on B next cycle, A still holds its word.
- ROUND bursts: BURST=4, mode=1, both channels ready; stream 0x0001..0x0008 back-to-back.
  - 0x0001–0x0004 appear on A and 0x0005–0x0008 appear on B.
  - cur_sel goes 0→1 after the 4th accept and 1→0 after the 8th.
  - burst_cnt sequence: 1,2,3,0,1,2,3,0.
- Reset mid-operation: reach the state a_valid=1, a_ready=0, cur_sel=1, burst_cnt=2, then pulse reset for 1 cycle while in_valid=1.
  - Required: all outputs at reset values next cycle, and the held word and the presented word are both not delivered.
